// File: rtl/mac_header_extractor.sv
// Byte-serial Ethernet header extractor: captures DA/SA, hashes both by XOR-folding,
// and issues one-cycle lookup/learn pulses; frames truncated before the header completes are counted as runts.
module mac_header_extractor #(
  parameter int pPORT_NUM = 4,
  parameter int pSLOTS    = 256
) (
  input  logic                         iclk,
  input  logic                         irst_n,
  input  logic [7:0]                   i_data,
  input  logic                         i_valid,
  input  logic                         i_sof,
  input  logic                         i_eof,
  input  logic [$clog2(pPORT_NUM)-1:0] i_port,
  output logic                         o_write_enable,
  output logic                         o_lookup_valid,
  output logic [$clog2(pPORT_NUM)-1:0] o_port_num,
  output logic [$clog2(pSLOTS)-1:0]    o_MAC_SA,
  output logic [$clog2(pSLOTS)-1:0]    o_MAC_DA,
  output logic                         o_bcast,
  output logic [15:0]                  o_runt_cnt
);

  localparam int P = $clog2(pPORT_NUM);
  localparam int H = $clog2(pSLOTS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DA   = 2'd1,
    SA   = 2'd2,
    SKIP = 2'd3
  } stateE;

  // Fold a 48-bit MAC into H bits; bit i lands on bit (i mod H), which zero-pads the top chunk.
  function automatic logic [H-1:0] foldMac(input logic [47:0] mac);
    logic [H-1:0] acc;
    acc = '0;
    for (int i = 0; i < 48; i++) begin
      acc[i % H] = acc[i % H] ^ mac[i];
    end
    return acc;
  endfunction

  stateE        stateR, stateS;
  logic [2:0]   cntR, cntS;
  logic [47:0]  daR, daS;
  logic [47:0]  saR, saS;
  logic [P-1:0] portR, portS;
  logic [1:0]   runtIncS;
  logic         completeS;
  logic [16:0]  runtSumS;
  logic [15:0]  runtNextS;

  logic         lookupValidR;
  logic         writeEnableR;
  logic [P-1:0] portNumR;
  logic [H-1:0] macSaR;
  logic [H-1:0] macDaR;
  logic         bcastR;
  logic [15:0]  runtCntR;

  // Next-state, capture shift registers and runt accounting for one accepted byte.
  always_comb begin
    stateS    = stateR;
    cntS      = cntR;
    daS       = daR;
    saS       = saR;
    portS     = portR;
    runtIncS  = 2'd0;
    completeS = 1'b0;
    if (i_valid) begin
      case (stateR)
        IDLE: begin
          if (i_sof && i_eof) begin
            runtIncS = 2'd1;
          end else if (i_sof) begin
            portS  = i_port;
            daS    = {40'd0, i_data};
            stateS = DA;
            cntS   = 3'd1;
          end else begin
            stateS = IDLE;
          end
        end
        DA, SA: begin
          // A new sof abandons the partial header; a one-byte sof+eof frame is a runt of its own.
          if (i_sof && i_eof) begin
            runtIncS = 2'd2;
            stateS   = IDLE;
            cntS     = 3'd0;
          end else if (i_sof) begin
            runtIncS = 2'd1;
            portS    = i_port;
            daS      = {40'd0, i_data};
            stateS   = DA;
            cntS     = 3'd1;
          end else if (i_eof && !(stateR == SA && cntR == 3'd5)) begin
            runtIncS = 2'd1;
            stateS   = IDLE;
            cntS     = 3'd0;
          end else if (stateR == DA) begin
            daS = {daR[39:0], i_data};
            if (cntR == 3'd5) begin
              stateS = SA;
              cntS   = 3'd0;
            end else begin
              cntS = cntR + 3'd1;
            end
          end else begin
            saS = {saR[39:0], i_data};
            if (cntR == 3'd5) begin
              completeS = 1'b1;
              stateS    = i_eof ? IDLE : SKIP;
              cntS      = 3'd0;
            end else begin
              cntS = cntR + 3'd1;
            end
          end
        end
        SKIP: begin
          if (i_sof && i_eof) begin
            runtIncS = 2'd1;
            stateS   = IDLE;
          end else if (i_sof) begin
            portS  = i_port;
            daS    = {40'd0, i_data};
            stateS = DA;
            cntS   = 3'd1;
          end else if (i_eof) begin
            stateS = IDLE;
          end else begin
            stateS = SKIP;
          end
        end
        default: begin
          stateS = IDLE;
          cntS   = 3'd0;
        end
      endcase
    end else begin
      stateS = stateR;
    end
  end

  // Saturating runt counter increment.
  always_comb begin
    runtSumS = {1'b0, runtCntR} + {15'd0, runtIncS};
    if (runtSumS[16]) begin
      runtNextS = 16'hFFFF;
    end else begin
      runtNextS = runtSumS[15:0];
    end
  end

  // FSM and capture registers.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      stateR   <= IDLE;
      cntR     <= 3'd0;
      daR      <= 48'd0;
      saR      <= 48'd0;
      portR    <= '0;
      runtCntR <= 16'd0;
    end else begin
      stateR   <= stateS;
      cntR     <= cntS;
      daR      <= daS;
      saR      <= saS;
      portR    <= portS;
      runtCntR <= runtNextS;
    end
  end

  // Registered header outputs; the header fields hold between completions.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      lookupValidR <= 1'b0;
      writeEnableR <= 1'b0;
      portNumR     <= '0;
      macSaR       <= '0;
      macDaR       <= '0;
      bcastR       <= 1'b0;
    end else begin
      lookupValidR <= completeS;
      // Bit 40 is the group bit of the first SA byte: multicast sources are never learned.
      writeEnableR <= completeS & ~saS[40];
      if (completeS) begin
        portNumR <= portR;
        macSaR   <= foldMac(saS);
        macDaR   <= foldMac(daR);
        bcastR   <= &daR;
      end
    end
  end

  assign o_lookup_valid = lookupValidR;
  assign o_write_enable = writeEnableR;
  assign o_port_num     = portNumR;
  assign o_MAC_SA       = macSaR;
  assign o_MAC_DA       = macDaR;
  assign o_bcast        = bcastR;
  assign o_runt_cnt     = runtCntR;

endmodule
